// File: rtl/spi_responder.sv
// -----------------------------------------------------------------------------
// spi_responder
//   SPI target, mode 0 (CPOL=0, CPHA=0), MSB first. SCLK, CS_n and MOSI are
//   oversampled in the clk domain. Received words are presented on a one-clk
//   rx_valid pulse. Reply words enter through a one-deep valid/ready holding
//   register. MISO has a separate output enable for a bidirectional pad.
//
// Ports
//   clk          system clock (SCLK must not exceed clk/8)
//   resetn       synchronous active-low reset
//   spi_sclk     SPI clock from the initiator (asynchronous)
//   spi_cs_n     chip select, active low (asynchronous)
//   spi_mosi     serial data in (asynchronous)
//   spi_miso     serial data out
//   spi_miso_oe  MISO pad enable, high only while selected
//   tx_data      reply word
//   tx_valid     tx_data is valid
//   tx_ready     holding register is empty
//   rx_data      last complete received word
//   rx_valid     one-clk pulse, rx_data updated
//   tx_underrun  one-clk pulse, TX_IDLE loaded because holding register empty
//   busy         selected (synchronised CS_n low)
// -----------------------------------------------------------------------------
module spi_responder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchroniser chains plus history flops for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_hist_r;
  logic                   cs_hist_r;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic cs_fall_s;
  logic cs_rise_s;

  // Holding register.
  logic                  hold_full_r;
  logic [DATA_WIDTH-1:0] hold_data_r;
  logic                  write_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] load_word_s;

  // Shift engine.
  state_t                state_r;
  logic [DATA_WIDTH-1:0] shift_tx_r;
  logic [DATA_WIDTH-2:0] shift_rx_r;
  logic [DATA_WIDTH-1:0] rx_word_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  reload_pending_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r;
  logic                  tx_underrun_r;

  // Input synchronisers; idle levels are SCLK low, CS_n high, MOSI low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_hist_r <= 1'b0;
      cs_hist_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_hist_r;
  assign sclk_fall_s = ~sclk_s & sclk_hist_r;
  assign cs_fall_s   = ~cs_s & cs_hist_r;
  assign cs_rise_s   = cs_s & ~cs_hist_r;

  // A write is only possible while the holding register is empty.
  assign write_s = tx_valid & ~hold_full_r;

  // Loads happen at selection and on the falling edge that follows a
  // completed word; deselection takes priority over any SCLK edge.
  assign load_s = ((state_r == ST_IDLE) && cs_fall_s) ||
                  ((state_r == ST_SHIFT) && !cs_rise_s && !sclk_rise_s &&
                   sclk_fall_s && reload_pending_r);

  // Next reply word: held data, or the idle pattern when nothing is held.
  always_comb begin
    load_word_s = TX_IDLE;
    if (hold_full_r) begin
      load_word_s = hold_data_r;
    end else begin
      load_word_s = TX_IDLE;
    end
  end

  // Word completed by the current rising edge, including the new bit.
  assign rx_word_s = {shift_rx_r, mosi_s};

  // Holding register: a load sees the state at the start of the clk, so a
  // write in the same clk survives for the following word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      hold_full_r <= write_s | (hold_full_r & ~load_s);
      if (write_s) begin
        hold_data_r <= tx_data;
      end
    end
  end

  // Main state machine: selection, bit shifting, word completion and reload.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r          <= ST_IDLE;
      shift_tx_r       <= {DATA_WIDTH{1'b0}};
      shift_rx_r       <= {(DATA_WIDTH-1){1'b0}};
      bit_cnt_r        <= {CNT_W{1'b0}};
      reload_pending_r <= 1'b0;
      busy_r           <= 1'b0;
      rx_data_r        <= {DATA_WIDTH{1'b0}};
      rx_valid_r       <= 1'b0;
      tx_underrun_r    <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      tx_underrun_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cs_fall_s) begin
            state_r          <= ST_SHIFT;
            shift_tx_r       <= load_word_s;
            tx_underrun_r    <= ~hold_full_r;
            bit_cnt_r        <= {CNT_W{1'b0}};
            reload_pending_r <= 1'b0;
            busy_r           <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            // Abort or normal end: any partial word is dropped and MISO
            // returns low so the pad sees a clean level when disabled.
            state_r          <= ST_IDLE;
            shift_tx_r       <= {DATA_WIDTH{1'b0}};
            bit_cnt_r        <= {CNT_W{1'b0}};
            reload_pending_r <= 1'b0;
            busy_r           <= 1'b0;
          end else if (sclk_rise_s) begin
            shift_rx_r <= rx_word_s[DATA_WIDTH-2:0];
            if (bit_cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
              rx_data_r        <= rx_word_s;
              rx_valid_r       <= 1'b1;
              bit_cnt_r        <= {CNT_W{1'b0}};
              reload_pending_r <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end else if (sclk_fall_s) begin
            if (reload_pending_r) begin
              shift_tx_r       <= load_word_s;
              tx_underrun_r    <= ~hold_full_r;
              reload_pending_r <= 1'b0;
            end else begin
              shift_tx_r <= {shift_tx_r[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          shift_tx_r       <= {DATA_WIDTH{1'b0}};
          bit_cnt_r        <= {CNT_W{1'b0}};
          reload_pending_r <= 1'b0;
          busy_r           <= 1'b0;
        end
      endcase
    end
  end

  // All outputs come straight from flops; MISO is the shift register MSB,
  // which is held at zero whenever the responder is not selected.
  assign spi_miso    = shift_tx_r[DATA_WIDTH-1];
  assign spi_miso_oe = busy_r;
  assign busy        = busy_r;
  assign tx_ready    = ~hold_full_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_underrun = tx_underrun_r;

endmodule
